cyclic_encoder_7_4: RTL and testbench

Sequential systematic (7,4) cyclic encoder. It is the transmit-side counterpart of the team's serial (7,4) cyclic syndrome decoder and uses the same default generator g(x)=x^3+x+1.
- Accepts a 4-bit message through a valid/ready handshake.
- Computes parity with a 3-stage LFSR divider.
- Streams the 7-bit codeword serially, high-order bit first, then presents it in parallel under a second valid/ready handshake.
- Sits between the message source and the channel/decoder path.

---
 rtl/cyclic_encoder_7_4.sv | 108 ++++++++++
 tb/tb_cyclic_encoder_7_4.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_encoder_7_4.sv
// Serial systematic (7,4) cyclic encoder.
// A message accepted on the input handshake is shifted through a 3-stage
// LFSR divider. The full codeword c[6]..c[0] is streamed on ser_bit, and
// then presented in parallel on c under an output valid/ready handshake.
// POLY holds the low generator coefficients {g2,g1,g0}. The x^3 term is
// implicit, and g0 must be 1.
module cyclic_encoder_7_4 #(
  parameter logic [2:0] POLY = 3'b011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] m,
  output logic       ser_valid,
  output logic       ser_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lfsr;     // {r2, r1, r0}
  logic [3:0] mbuf;
  logic [1:0] cnt;
  logic       msg_bit;
  logic       fb;

  // Accept only from IDLE, and never while reset is being applied.
  assign in_ready = (state == IDLE) && rst_n;

  // Next-state decode plus the divider feedback bit for the current message bit.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt = state;
    msg_bit   = mbuf[cnt];
    fb        = msg_bit ^ lfsr[2];
    case (state)
      IDLE: if (in_valid)                state_nxt = MSG;
      MSG:  if (cnt == 2'd0)             state_nxt = PAR;
      PAR:  if (cnt == 2'd0)             state_nxt = DONE;
      DONE: if (out_valid && out_ready)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // State register, LFSR divider, serial output and parallel codeword capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values and order does not matter.
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= '0;
      mbuf      <= '0;
      cnt       <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          ser_valid <= 1'b0;
          out_valid <= 1'b0;
          if (in_valid) begin
            mbuf <= m;
            lfsr <= '0;
            cnt  <= 2'd3;
          end
        end
        MSG: begin
          // Divide m(x)*x^3 by g(x), taking the high-order bit first.
          lfsr      <= {lfsr[1] ^ (fb & POLY[2]),
                        lfsr[0] ^ (fb & POLY[1]),
                        fb & POLY[0]};
          ser_bit   <= msg_bit;
          ser_valid <= 1'b1;
          cnt       <= (cnt == 2'd0) ? 2'd2 : cnt - 2'd1;
        end
        PAR: begin
          // The remainder is complete. Shift it out without feedback.
          ser_bit   <= lfsr[2];
          ser_valid <= 1'b1;
          lfsr      <= {lfsr[1:0], 1'b0};
          if (cnt == 2'd2) c <= {mbuf, lfsr};
          cnt       <= cnt - 2'd1;
        end
        DONE: begin
          ser_valid <= 1'b0;
          out_valid <= !(out_valid && out_ready);
        end
        default: begin
          ser_valid <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cyclic_encoder_7_4.sv
// Self-checking bench for cyclic_encoder_7_4.
// Expected codewords come from GF(2) long division of m(x)*x^3 by g(x).
// A syndrome-table decoder model closes the loopback path.
module tb_cyclic_encoder_7_4;

  localparam logic [6:0] GEN7 = 7'b0001011;  // x^3 + x + 1

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] m;
  logic       ser_valid;
  logic       ser_bit;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] c;

  int checks = 0;
  int errors = 0;

  cyclic_encoder_7_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of w(x) mod g(x), computed by plain polynomial long division.
  function automatic logic [2:0] poly_rem(input logic [6:0] w);
    logic [6:0] r;
    r = w;
    for (int i = 6; i >= 3; i--)
      if (r[i]) r = r ^ (GEN7 << (i - 3));
    return r[2:0];
  endfunction

  function automatic logic [6:0] ref_encode(input logic [3:0] msg);
    logic [6:0] shifted;
    shifted = {msg, 3'b000};
    return shifted | {4'b0000, poly_rem(shifted)};
  endfunction

  // Single-error-correcting decoder: match the syndrome against x^p mod g.
  function automatic logic [6:0] ref_decode(input logic [6:0] w);
    logic [2:0] syn;
    logic [6:0] one;
    logic [6:0] fixed;
    syn   = poly_rem(w);
    fixed = w;
    if (syn != 3'b000)
      for (int p = 0; p < 7; p++) begin
        one = 7'b1 << p;
        if (poly_rem(one) == syn) fixed = w ^ one;
      end
    return fixed;
  endfunction

  // Run one codeword: accept, 7 serial bits, parallel output, optional stall.
  task automatic encode(input logic [3:0] msg, input logic [6:0] exp_c, input int stall,
                        input logic hold_nxt, input logic [3:0] nxt_m, input logic poke,
                        output logic [6:0] c_obs);
    int budget;
    budget    = 0;
    c_obs     = '0;
    in_valid  = 1'b1;
    m         = msg;
    out_ready = (stall == 0);
    while (!in_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();  // accept edge T
    in_valid = hold_nxt;
    m        = hold_nxt ? nxt_m : 4'($urandom);
    for (int k = 1; k <= 7; k++) begin
      if (poke && k == 2) begin
        in_valid = 1'b1;
        m        = ~msg;
      end else if (poke && k == 3) begin
        in_valid = hold_nxt;
        m        = nxt_m;
      end
      tick();
      check("ser_valid", 32'(ser_valid), 32'd1);
      check("ser_bit",   32'(ser_bit),   32'(exp_c[7-k]));
      check("ov_early",  32'(out_valid), 32'd0);
      check("ir_busy",   32'(in_ready),  32'd0);
    end
    tick();  // edge T+8
    check("ser_end",  32'(ser_valid), 32'd0);
    check("ov_rise",  32'(out_valid), 32'd1);
    check("c_word",   32'(c),         32'(exp_c));
    check("ir_done",  32'(in_ready),  32'd0);
    c_obs = c;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("ov_hold", 32'(out_valid), 32'd1);
      check("c_hold",  32'(c),         32'(exp_c));
      check("ir_hold", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();  // handshake edge
    check("ov_fall", 32'(out_valid), 32'd0);
    check("ir_back", 32'(in_ready),  32'd1);
    check("c_keep",  32'(c),         32'(exp_c));
  endtask

  initial begin : main
    logic [6:0] c_obs;
    logic [3:0] rm;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    m         = 4'h0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_bit",   32'(ser_bit),   32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c",         32'(c),         32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed codewords.
    encode(4'b0001, 7'b0001011, 0, 1'b0, 4'h0, 1'b0, c_obs);
    encode(4'b1000, 7'b1000101, 0, 1'b0, 4'h0, 1'b0, c_obs);
    encode(4'b1011, 7'b1011000, 0, 1'b0, 4'h0, 1'b0, c_obs);
    encode(4'b1111, 7'b1111111, 0, 1'b0, 4'h0, 1'b0, c_obs);
    encode(4'b0000, 7'b0000000, 0, 1'b0, 4'h0, 1'b0, c_obs);

    // Backpressure, plus an unaccepted in_valid pulse during MSG.
    encode(4'b1000, 7'b1000101, 5, 1'b0, 4'h0, 1'b1, c_obs);
    tick();
    check("poke_ignored", 32'(ser_valid), 32'd0);

    // Back-to-back with in_valid held across the first codeword.
    encode(4'b0001, 7'b0001011, 0, 1'b1, 4'b1011, 1'b0, c_obs);
    encode(4'b1011, 7'b1011000, 0, 1'b0, 4'h0, 1'b0, c_obs);

    // Reset asserted for one edge during PAR.
    in_valid  = 1'b1;
    m         = 4'b1111;
    out_ready = 1'b1;
    tick();  // accept
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();  // first PAR edge done
    rst_n = 1'b0;
    tick();
    check("abort_ser_valid", 32'(ser_valid), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_c",         32'(c),         32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_quiet_ser", 32'(ser_valid), 32'd0);
      check("abort_quiet_ov",  32'(out_valid), 32'd0);
    end

    // Loopback over all 16 messages with random stalls and pokes.
    for (int i = 0; i < 16; i++) begin
      rm = 4'(i);
      encode(rm, ref_encode(rm), int'($urandom_range(0, 2)), 1'b0, 4'h0,
             1'($urandom_range(0, 1)), c_obs);
      check("loop_clean", 32'(ref_decode(c_obs)), 32'(ref_encode(rm)));
      for (int p = 0; p < 7; p++)
        check("loop_flip", 32'(ref_decode(c_obs ^ (7'b1 << p))), 32'(ref_encode(rm)));
    end

    // Random traffic.
    for (int i = 0; i < 12; i++) begin
      rm = 4'($urandom);
      encode(rm, ref_encode(rm), int'($urandom_range(0, 3)), 1'b0, 4'h0,
             1'($urandom_range(0, 1)), c_obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
